// File: rtl/ws2811_frame_receiver_if.sv
// ws2811_frame_receiver_if
//   Bundles the decoder-side inputs and the frame-side outputs of the
//   WS2811 frame receiver.
//   master : the decoder/consumer side (drives dataIn, dataClk, active, frameAck)
//   slave  : the receiver (drives frameData, frameValid, frameErr, overrun, bitCount)
interface ws2811_frame_receiver_if #(
  parameter int FRAME_BITS = 32,
  parameter int CNT_W      = 8
);
  logic                  dataIn;
  logic                  dataClk;
  logic                  active;
  logic                  frameAck;
  logic [FRAME_BITS-1:0] frameData;
  logic                  frameValid;
  logic                  frameErr;
  logic                  overrun;
  logic [CNT_W-1:0]      bitCount;

  modport master (
    output dataIn, dataClk, active, frameAck,
    input  frameData, frameValid, frameErr, overrun, bitCount
  );

  modport slave (
    input  dataIn, dataClk, active, frameAck,
    output frameData, frameValid, frameErr, overrun, bitCount
  );
endinterface

// File: rtl/ws2811_frame_receiver.sv
// ws2811_frame_receiver
//   Assembles the bit stream of a ws2811 decoder into frames. Bits arrive on
//   rising edges of dataClk while active is high; the falling edge of active
//   ends the frame and the frame is presented on frameData/frameValid until
//   acknowledged.
//   masterClk : sole clock
//   rst       : asynchronous active-high reset
//   bus       : slave side of ws2811_frame_receiver_if
//               in : dataIn, dataClk, active, frameAck
//               out: frameData (first bit at MSB), frameValid, frameErr,
//                    overrun (sticky), bitCount
module ws2811_frame_receiver #(
  parameter int FRAME_BITS = 32,
  parameter int CNT_W      = 8
) (
  input  logic                    masterClk,
  input  logic                    rst,
  ws2811_frame_receiver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECEIVE, COMPLETE} state_t;

  localparam logic [31:0]      FRAME_LEN = 32'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t                state_reg;
  logic                  data_clk_reg;
  logic                  data_clk_prev;
  logic                  data_in_reg;
  logic                  active_reg;
  logic                  active_prev;
  logic                  start_pending_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [FRAME_BITS-1:0] frame_data_reg;
  logic [CNT_W-1:0]      bit_count_reg;
  logic                  frame_valid_reg;
  logic                  frame_err_reg;
  logic                  overrun_reg;

  logic clk_rise;
  logic active_rise;
  logic active_fall;

  // Edges are taken between the input register and its prev copy, so every
  // decision is made one cycle after the pins are sampled.
  assign clk_rise    = data_clk_reg & ~data_clk_prev;
  assign active_rise = active_reg & ~active_prev;
  assign active_fall = ~active_reg & active_prev;

  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      data_clk_reg      <= 1'b0;
      data_clk_prev     <= 1'b0;
      data_in_reg       <= 1'b0;
      active_reg        <= 1'b0;
      active_prev       <= 1'b0;
      start_pending_reg <= 1'b0;
      shift_reg         <= '0;
      cnt_reg           <= '0;
      frame_data_reg    <= '0;
      bit_count_reg     <= '0;
      frame_valid_reg   <= 1'b0;
      frame_err_reg     <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      data_clk_reg  <= bus.dataClk;
      data_clk_prev <= data_clk_reg;
      data_in_reg   <= bus.dataIn;
      active_reg    <= bus.active;
      active_prev   <= active_reg;

      case (state_reg)
        IDLE: begin
          // A start seen during COMPLETE is remembered and honoured here.
          if (active_rise || start_pending_reg) begin
            state_reg         <= RECEIVE;
            shift_reg         <= '0;
            cnt_reg           <= '0;
            start_pending_reg <= 1'b0;
          end
        end

        RECEIVE: begin
          // A bit arriving together with end-of-frame still belongs to it.
          if (clk_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], data_in_reg};
            if (cnt_reg != CNT_MAX)
              cnt_reg <= cnt_reg + 1'b1;
          end
          if (active_fall)
            state_reg <= COMPLETE;
        end

        COMPLETE: begin
          state_reg <= IDLE;
          if (active_rise)
            start_pending_reg <= 1'b1;
          // An ack in this very cycle frees the output slot for the new frame.
          if (!frame_valid_reg || bus.frameAck) begin
            frame_data_reg  <= shift_reg;
            bit_count_reg   <= cnt_reg;
            frame_err_reg   <= (32'(cnt_reg) != FRAME_LEN);
            frame_valid_reg <= 1'b1;
          end else begin
            overrun_reg <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase

      if (state_reg != COMPLETE && frame_valid_reg && bus.frameAck)
        frame_valid_reg <= 1'b0;
    end
  end

  assign bus.frameData  = frame_data_reg;
  assign bus.frameValid = frame_valid_reg;
  assign bus.frameErr   = frame_err_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.bitCount   = bit_count_reg;

endmodule

// File: tb/tb_ws2811_frame_receiver.sv
// tb_ws2811_frame_receiver
//   Self-checking bench for ws2811_frame_receiver: a table of frames driven
//   through a decoder model with results checked via a scoreboard queue, plus
//   hand-written sequences for overrun, reset, back-to-back start and
//   counter saturation.
module tb_ws2811_frame_receiver;

  localparam int FB = 32;
  localparam int CW = 8;

  logic masterClk = 1'b0;
  logic rst       = 1'b1;

  ws2811_frame_receiver_if #(.FRAME_BITS(FB), .CNT_W(CW)) bus ();

  ws2811_frame_receiver #(.FRAME_BITS(FB), .CNT_W(CW)) dut (
    .masterClk (masterClk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 masterClk = ~masterClk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  typedef struct {
    logic [39:0] bytes;
    int          nbits;
    bit          coinc;
    logic [31:0] exp_data;
    logic [7:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge masterClk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.dataIn  = b;
    bus.dataClk = 1'b1;
    tick(2);
    bus.dataClk = 1'b0;
    tick(2);
  endtask

  // Sends nbits of bytes, MSB first, then drops active. With coinc set the
  // final dataClk rise and the active fall are driven together.
  task automatic send_bits(input logic [39:0] bytes, input int nbits, input bit coinc);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (coinc && i == 0) begin
        bus.dataIn  = bytes[i];
        bus.dataClk = 1'b1;
        bus.active  = 1'b0;
        return;
      end
      send_bit(bytes[i]);
    end
    bus.active = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] bytes, input int nbits, input bit coinc);
    bus.dataClk = 1'b0;
    bus.active  = 1'b1;
    tick(3);
    send_bits(bytes, nbits, coinc);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!bus.frameValid && edges < 40) begin
      @(posedge masterClk);
      #1;
      edges++;
    end
  endtask

  // Waits for the frame, checks latency (if exp_edges>0), pops the scoreboard.
  task automatic collect(input string name, input int exp_edges);
    int   edges;
    exp_t e;
    wait_valid(edges);
    if (exp_edges > 0) check({name, " latency"}, 64'(edges), 64'(exp_edges));
    else               check({name, " valid"}, 64'(bus.frameValid), 64'd1);
    e = sb.pop_front();
    check({name, " data"}, 64'(bus.frameData), 64'(e.data));
    check({name, " count"}, 64'(bus.bitCount), 64'(e.cnt));
    check({name, " err"}, 64'(bus.frameErr), 64'(e.err));
    $display("[TB] %s: data=%h count=%0d err=%0b overrun=%0b",
             name, bus.frameData, bus.bitCount, bus.frameErr, bus.overrun);
  endtask

  task automatic push(input logic [31:0] d, input logic [7:0] c, input logic er);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    e.err  = er;
    sb.push_back(e);
  endtask

  task automatic ack();
    bus.frameAck = 1'b1;
    tick(1);
    bus.frameAck = 1'b0;
  endtask

  initial begin
    bus.dataIn   = 1'b0;
    bus.dataClk  = 1'b0;
    bus.active   = 1'b0;
    bus.frameAck = 1'b0;

    vecs[0] = '{40'h0055AA00FF, 32, 1'b0, 32'h55AA00FF, 8'd32, 1'b0};
    vecs[1] = '{40'h0000ABCDEF, 24, 1'b0, 32'h00ABCDEF, 8'd24, 1'b1};
    vecs[2] = '{40'h1122334455, 40, 1'b0, 32'h22334455, 8'd40, 1'b1};
    vecs[3] = '{40'h0000000000,  0, 1'b0, 32'h00000000, 8'd0,  1'b1};
    vecs[4] = '{40'h0012345678, 32, 1'b1, 32'h12345678, 8'd32, 1'b0};
    vecs[5] = '{40'h005A5A5A5A, 31, 1'b0, 32'h5A5A5A5A, 8'd31, 1'b1};

    // Reset state
    #3;
    check("rst frameValid", 64'(bus.frameValid), 64'd0);
    check("rst frameData", 64'(bus.frameData), 64'd0);
    check("rst bitCount", 64'(bus.bitCount), 64'd0);
    check("rst frameErr", 64'(bus.frameErr), 64'd0);
    check("rst overrun", 64'(bus.overrun), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].bytes, vecs[v].nbits, vecs[v].coinc);
      push(vecs[v].exp_data, vecs[v].exp_cnt, vecs[v].exp_err);
      collect($sformatf("vec%0d", v), 3);
      tick(3);
      check($sformatf("vec%0d held", v), 64'(bus.frameValid), 64'd1);
      ack();
      check($sformatf("vec%0d ack clear", v), 64'(bus.frameValid), 64'd0);
      check($sformatf("vec%0d data hold", v), 64'(bus.frameData), 64'(vecs[v].exp_data));
      ack();
      check($sformatf("vec%0d idle ack", v), 64'(bus.frameValid), 64'd0);
      check($sformatf("vec%0d idle ack cnt", v), 64'(bus.bitCount), 64'(vecs[v].exp_cnt));
    end

    // Counter saturation: 300 alternating bits, last 32 are 0101...
    bus.dataClk = 1'b0;
    bus.active  = 1'b1;
    tick(3);
    for (int i = 0; i < 300; i++) send_bit(i[0]);
    bus.active = 1'b0;
    push(32'h55555555, 8'd255, 1'b1);
    collect("saturate", 3);
    ack();

    // Overrun without ack, then sticky check and asynchronous reset
    send_frame(40'h01020304, 32, 1'b0);
    push(32'h01020304, 8'd32, 1'b0);
    collect("ovr first", 3);
    send_frame(40'h0A0B0C0D, 32, 1'b0);
    tick(5);
    check("ovr data kept", 64'(bus.frameData), 64'h01020304);
    check("ovr flag", 64'(bus.overrun), 64'd1);
    check("ovr valid", 64'(bus.frameValid), 64'd1);
    ack();
    tick(2);
    check("ovr sticky", 64'(bus.overrun), 64'd1);
    rst = 1'b1;
    #1;
    check("async rst overrun", 64'(bus.overrun), 64'd0);
    check("async rst valid", 64'(bus.frameValid), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Same pair with ack in the COMPLETE cycle of the second frame
    send_frame(40'h01020304, 32, 1'b0);
    push(32'h01020304, 8'd32, 1'b0);
    collect("ack first", 3);
    send_frame(40'h0A0B0C0D, 32, 1'b0);
    tick(2);
    bus.frameAck = 1'b1;
    tick(1);
    bus.frameAck = 1'b0;
    check("ack cplt data", 64'(bus.frameData), 64'h0A0B0C0D);
    check("ack cplt overrun", 64'(bus.overrun), 64'd0);
    check("ack cplt valid", 64'(bus.frameValid), 64'd1);
    $display("[TB] ack-in-complete: data=%h overrun=%0b", bus.frameData, bus.overrun);
    ack();

    // Reset in the middle of a frame
    bus.dataClk = 1'b0;
    bus.active  = 1'b1;
    tick(3);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    rst = 1'b1;
    bus.active = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(12);
    check("abort no valid", 64'(bus.frameValid), 64'd0);
    $display("[TB] aborted frame: valid=%0b", bus.frameValid);
    send_frame(40'hDEADBEEF, 32, 1'b0);
    push(32'hDEADBEEF, 8'd32, 1'b0);
    collect("after abort", 3);
    ack();

    // New start while COMPLETE: active low for one sample only
    bus.dataClk = 1'b0;
    bus.active  = 1'b1;
    tick(3);
    send_bits(40'h0F0F0F0F, 32, 1'b0);
    tick(1);
    bus.active = 1'b1;
    push(32'h0F0F0F0F, 8'd32, 1'b0);
    collect("pending first", 2);
    ack();
    send_bits(40'h13579BDF, 32, 1'b0);
    push(32'h13579BDF, 8'd32, 1'b0);
    collect("pending second", 3);
    ack();
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws2811_frame_receiver.md
WS2811_FRAME_RECEIVER -- requirements
Module: ws2811_frame_receiver

Interface
REQ-001 Parameter FRAME_BITS, default 32: expected frame length in bits; frameData width.
REQ-002 Parameter CNT_W, default 8: width of bitCount; the count saturates at 2^CNT_W-1.
REQ-003 masterClk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 dataIn  in  1  decoded bit from the upstream ws2811Decoder; valid when dataClk rises.
REQ-006 dataClk  in  1  decoder bit strobe, a level signal in the masterClk domain; each rising edge marks one bit.
REQ-007 active  in  1  decoder frame-active level; a falling edge marks end of frame.
REQ-008 frameAck  in  1  consumer acknowledge; clears frameValid.
REQ-009 frameData  out  FRAME_BITS  last captured frame; first-received bit at the MSB.
REQ-010 frameValid  out  1  captured frame pending; held high until acknowledged.
REQ-011 frameErr  out  1  the captured frame's bit count was not equal to FRAME_BITS.
REQ-012 overrun  out  1  sticky flag: a frame completed while frameValid was still high.
REQ-013 bitCount  out  CNT_W  number of bits in the captured frame.

Function
REQ-014 dataClk, dataIn and active shall each pass through one register stage (prev copies) for edge detection; no further synchronisation is required.
REQ-015 FSM states shall be IDLE, RECEIVE and COMPLETE.
REQ-016 IDLE -> RECEIVE on the registered active rising edge; on that transition the shift register and the bit counter shall be cleared to 0.
REQ-017 RECEIVE: each registered dataClk rising edge shall shift the register left by one, load dataIn into bit 0, and increment the counter (saturating).
REQ-018 More than FRAME_BITS bits: the shift register shall retain the last FRAME_BITS bits received.
REQ-019 RECEIVE -> COMPLETE on the registered active falling edge; a dataClk edge in the same cycle shall be shifted in and counted first.
REQ-020 COMPLETE shall last exactly one cycle, then return to IDLE.
REQ-021 Capture, when frameValid=0 or frameAck=1 in the COMPLETE cycle: frameData <= shift register, bitCount <= counter, frameErr <= (counter != FRAME_BITS), frameValid <= 1.
REQ-022 Overrun, when frameValid=1 and frameAck=0 in the COMPLETE cycle: frameData, bitCount and frameErr shall be unchanged, and overrun <= 1.
REQ-023 frameValid latency: it shall rise on the second masterClk edge after the first edge that samples active=0.
REQ-024 frameAck with frameValid=1 outside COMPLETE: frameValid <= 0 on the next edge; frameData, frameErr and bitCount hold.
REQ-025 frameAck with frameValid=0 shall have no effect.
REQ-026 overrun shall clear only on rst.
REQ-027 A frame with zero bits (active pulse without dataClk) shall be captured: frameData=0, bitCount=0, frameErr=1.
REQ-028 active rising while in COMPLETE shall be taken as a new frame start on the following IDLE cycle.

Reset
REQ-029 While rst=1: state=IDLE; shift register, counter, frameData, bitCount, frameValid, frameErr, overrun and all edge-detect registers = 0.
REQ-030 Reset asserted mid-frame shall discard the partial frame; no frameValid shall result from it after release.
REQ-031 After rst deasserts, edge detection shall use the reset prev values (0); an active already high at release counts as a rising edge.

Verification
REQ-032 Decoder driven with bytes 55,AA,00,FF then end-of-frame -> frameData=32'h55AAFF00 is wrong; required: frameData=32'h55AA00FF, bitCount=32, frameErr=0, frameValid=1 until frameAck.
REQ-033 24-bit frame AB,CD,EF -> frameData=32'h00ABCDEF, bitCount=24, frameErr=1.
REQ-034 40-bit frame 11,22,33,44,55 -> frameData=32'h22334455, bitCount=40, frameErr=1.
REQ-035 Two frames 0x01020304 then 0x0A0B0C0D with no frameAck -> frameData=32'h01020304, overrun=1; repeat with frameAck pulsed in the COMPLETE cycle -> frameData=32'h0A0B0C0D, overrun=0.
REQ-036 rst pulsed after 16 bits of a frame, then a full 0xDEADBEEF frame -> no frameValid for the aborted frame; then frameData=32'hDEADBEEF, bitCount=32, frameErr=0.
REQ-037 Frame with the final dataClk edge coincident with active falling -> the bit is included and bitCount=32.
